// File: rtl/usb_rx_deglitch_n.sv
// N-channel glitch filter for the USB 1.1 FS PHY receive path (D+/D-/diff).
// Optional 2-flop input synchroniser enabled by defining USB_RX_DEGLITCH_SYNC_EN.
module usb_rx_deglitch_n #(
  parameter int             NCH     = 2,
  parameter int             FILT    = 2,
  parameter logic [NCH-1:0] RST_VAL = NCH'(2'b01)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [NCH-1:0] din,
  output logic [NCH-1:0] dout,
  output logic [NCH-1:0] chg,
  output logic [NCH-1:0] glitch
);

  localparam int CNT_W = (FILT > 1) ? $clog2(FILT) : 1;

  logic [NCH-1:0] samp;

`ifdef USB_RX_DEGLITCH_SYNC_EN
  logic [NCH-1:0] sync_q1;
  logic [NCH-1:0] sync_q2;

  // Synchroniser resets to the output reset level so release causes no spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= RST_VAL;
      sync_q2 <= RST_VAL;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
    end
  end

  assign samp = sync_q2;
`else
  assign samp = din;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             dout_q;
    logic             chg_q;
    logic             glitch_q;

    // cnt counts consecutive samples differing from dout_q; it saturates at FILT-1
    // where the output toggles, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt      <= '0;
        dout_q   <= RST_VAL[i];
        chg_q    <= 1'b0;
        glitch_q <= 1'b0;
      end else if (!en) begin
        cnt      <= '0;
        chg_q    <= 1'b0;
        glitch_q <= 1'b0;
      end else if (samp[i] == dout_q) begin
        chg_q    <= 1'b0;
        glitch_q <= (cnt != '0);
        cnt      <= '0;
      end else if (cnt == CNT_W'(FILT - 1)) begin
        dout_q   <= samp[i];
        cnt      <= '0;
        chg_q    <= 1'b1;
        glitch_q <= 1'b0;
      end else begin
        cnt      <= cnt + 1'b1;
        chg_q    <= 1'b0;
        glitch_q <= 1'b0;
      end
    end

    assign dout[i]   = dout_q;
    assign chg[i]    = chg_q;
    assign glitch[i] = glitch_q;
  end

endmodule

// File: tb/tb_usb_rx_deglitch_n.sv
// Directed self-checking bench for usb_rx_deglitch_n using four instances (FILT=1,2,3,4).
// When USB_RX_DEGLITCH_SYNC_EN is defined every expected edge index shifts by SL=2.
module tb_usb_rx_deglitch_n;

`ifdef USB_RX_DEGLITCH_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic       en1, en2, en3, en4;
  logic [1:0] din1, din2, din3, din4;
  logic [1:0] dout1, dout2, dout3, dout4;
  logic [1:0] chg1, chg2, chg3, chg4;
  logic [1:0] gl1, gl2, gl3, gl4;

  always #5 clk = ~clk;

  usb_rx_deglitch_n #(.NCH(2), .FILT(1), .RST_VAL(2'b01)) u_f1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .din(din1), .dout(dout1), .chg(chg1), .glitch(gl1));
  usb_rx_deglitch_n #(.NCH(2), .FILT(2), .RST_VAL(2'b01)) u_f2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .din(din2), .dout(dout2), .chg(chg2), .glitch(gl2));
  usb_rx_deglitch_n #(.NCH(2), .FILT(3), .RST_VAL(2'b01)) u_f3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .din(din3), .dout(dout3), .chg(chg3), .glitch(gl3));
  usb_rx_deglitch_n #(.NCH(2), .FILT(4), .RST_VAL(2'b01)) u_f4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .din(din4), .dout(dout4), .chg(chg4), .glitch(gl4));

  // Advance to just after the next rising edge; inputs set here are sampled on the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] exp_d, exp_c;
    rst_n = 1'b0;
    din2  = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dout2 !== 2'b01) begin failures++; $display("[TB] FAIL reset_dout2 got=%b exp=01", dout2); end
    checks++; if (chg2 !== 2'b00) begin failures++; $display("[TB] FAIL reset_chg2 got=%b exp=00", chg2); end
    checks++; if (gl2 !== 2'b00) begin failures++; $display("[TB] FAIL reset_glitch2 got=%b exp=00", gl2); end
    checks++; if (dout4 !== 2'b01) begin failures++; $display("[TB] FAIL reset_dout4 got=%b exp=01", dout4); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 3 + SL; n++) begin
      tick();
      exp_d = (n >= 2 + SL) ? 2'b10 : 2'b01;
      exp_c = (n == 2 + SL) ? 2'b11 : 2'b00;
      checks++; if (dout2 !== exp_d) begin failures++; $display("[TB] FAIL release_dout edge=%0d got=%b exp=%b", n, dout2, exp_d); end
      checks++; if (chg2 !== exp_c) begin failures++; $display("[TB] FAIL release_chg edge=%0d got=%b exp=%b", n, chg2, exp_c); end
      checks++; if (gl2 !== 2'b00) begin failures++; $display("[TB] FAIL release_glitch edge=%0d got=%b exp=00", n, gl2); end
    end
  endtask

  task automatic test_clean_step();
    logic exp_d, exp_c;
    din4[0] = 1'b0;
    for (int n = 1; n <= 5 + SL; n++) begin
      tick();
      exp_d = (n >= 4 + SL) ? 1'b0 : 1'b1;
      exp_c = (n == 4 + SL);
      checks++; if (dout4[0] !== exp_d) begin failures++; $display("[TB] FAIL step_dout edge=%0d got=%b exp=%b", n, dout4[0], exp_d); end
      checks++; if (chg4[0] !== exp_c) begin failures++; $display("[TB] FAIL step_chg edge=%0d got=%b exp=%b", n, chg4[0], exp_c); end
      checks++; if (gl4 !== 2'b00) begin failures++; $display("[TB] FAIL step_glitch edge=%0d got=%b exp=00", n, gl4); end
    end
    din4[0] = 1'b1;
    repeat (6 + SL) tick();
    checks++; if (dout4 !== 2'b01) begin failures++; $display("[TB] FAIL step_restore got=%b exp=01", dout4); end
  endtask

  task automatic test_glitch_reject();
    logic exp_g, exp_d;
    din4[0] = 1'b0;
    repeat (3) tick();
    din4[0] = 1'b1;
    for (int n = 4; n <= 7 + SL; n++) begin
      tick();
      exp_g = (n == 4 + SL);
      checks++; if (gl4[0] !== exp_g) begin failures++; $display("[TB] FAIL reject_glitch edge=%0d got=%b exp=%b", n, gl4[0], exp_g); end
      checks++; if (dout4[0] !== 1'b1) begin failures++; $display("[TB] FAIL reject_dout edge=%0d got=%b exp=1", n, dout4[0]); end
      checks++; if (chg4 !== 2'b00) begin failures++; $display("[TB] FAIL reject_chg edge=%0d got=%b exp=00", n, chg4); end
    end
    // A fresh step must take the full four samples, showing the count was cleared.
    din4[0] = 1'b0;
    for (int n = 1; n <= 4 + SL; n++) begin
      tick();
      exp_d = (n >= 4 + SL) ? 1'b0 : 1'b1;
      checks++; if (dout4[0] !== exp_d) begin failures++; $display("[TB] FAIL reject_recount edge=%0d got=%b exp=%b", n, dout4[0], exp_d); end
    end
    din4[0] = 1'b1;
    repeat (6 + SL) tick();
  endtask

  task automatic test_enable_freeze();
    logic exp_d, exp_c;
    din3[0] = 1'b0;
    repeat (2 + SL) tick();
    en3 = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      tick();
      checks++; if (gl3 !== 2'b00) begin failures++; $display("[TB] FAIL freeze_glitch edge=%0d got=%b exp=00", n, gl3); end
      checks++; if (dout3 !== 2'b01) begin failures++; $display("[TB] FAIL freeze_dout edge=%0d got=%b exp=01", n, dout3); end
    end
    en3 = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick();
      exp_d = (n >= 3) ? 1'b0 : 1'b1;
      exp_c = (n == 3);
      checks++; if (dout3[0] !== exp_d) begin failures++; $display("[TB] FAIL resume_dout edge=%0d got=%b exp=%b", n, dout3[0], exp_d); end
      checks++; if (chg3[0] !== exp_c) begin failures++; $display("[TB] FAIL resume_chg edge=%0d got=%b exp=%b", n, chg3[0], exp_c); end
      checks++; if (gl3 !== 2'b00) begin failures++; $display("[TB] FAIL resume_glitch edge=%0d got=%b exp=00", n, gl3); end
    end
  endtask

  task automatic test_independent_channels();
    logic [1:0] exp_c, exp_g, exp_d;
    // dout2 is 10 here; ch0 steps to 1 while ch1 dips to 0 for a single sample.
    din2 = 2'b01;
    tick();
    din2 = 2'b11;
    for (int n = 2; n <= 4 + SL; n++) begin
      if (n > 2) tick();
      else #0;
      exp_c = (n == 2 + SL) ? 2'b01 : 2'b00;
      exp_g = (n == 2 + SL) ? 2'b10 : 2'b00;
      exp_d = (n >= 2 + SL) ? 2'b11 : 2'b10;
      if (n == 2) begin
        tick();
      end
      checks++; if (chg2 !== exp_c) begin failures++; $display("[TB] FAIL indep_chg edge=%0d got=%b exp=%b", n, chg2, exp_c); end
      checks++; if (gl2 !== exp_g) begin failures++; $display("[TB] FAIL indep_glitch edge=%0d got=%b exp=%b", n, gl2, exp_g); end
      checks++; if (dout2 !== exp_d) begin failures++; $display("[TB] FAIL indep_dout edge=%0d got=%b exp=%b", n, dout2, exp_d); end
    end
  endtask

  task automatic test_filt1_register();
    logic [1:0] exp_d, exp_c;
    din1 = 2'b10;
    tick();
    din1 = 2'b01;
    for (int n = 1; n <= 3 + SL; n++) begin
      if (n > 1) tick();
      exp_d = (n == 1 + SL) ? 2'b10 : 2'b01;
      exp_c = (n == 1 + SL || n == 2 + SL) ? 2'b11 : 2'b00;
      checks++; if (dout1 !== exp_d) begin failures++; $display("[TB] FAIL filt1_dout edge=%0d got=%b exp=%b", n, dout1, exp_d); end
      checks++; if (chg1 !== exp_c) begin failures++; $display("[TB] FAIL filt1_chg edge=%0d got=%b exp=%b", n, chg1, exp_c); end
      checks++; if (gl1 !== 2'b00) begin failures++; $display("[TB] FAIL filt1_glitch edge=%0d got=%b exp=00", n, gl1); end
    end
  endtask

  initial begin
    en1 = 1'b1; en2 = 1'b1; en3 = 1'b1; en4 = 1'b1;
    din1 = 2'b01; din2 = 2'b10; din3 = 2'b01; din4 = 2'b01;
    test_reset();
    test_clean_step();
    test_glitch_reject();
    test_enable_freeze();
    test_independent_channels();
    test_filt1_register();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
